// File: rtl/pixel_streamer.sv
// pixel_streamer: reads an 8-bit frame from a synchronous frame memory and streams it
// line by line, paced by filter line credits. Define PIXEL_STREAMER_PAD_EN to append one zero line.
module pixel_streamer #(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int ADDR_W      = 18,
  parameter int PRIME_LINES = 4
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  input  logic              i_data_ready,
  input  logic              intr,
  output logic              busy,
  output logic              done
);
`ifdef PIXEL_STREAMER_PAD_EN
  localparam int NUM_LINES = IMG_HEIGHT + 1;
`else
  localparam int NUM_LINES = IMG_HEIGHT;
`endif
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int LINE_W = $clog2(NUM_LINES + 1);
  localparam int CRED_W = $clog2(PRIME_LINES + 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(PRIME_LINES);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_CREDIT, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        e0_q, e0_d, e1_q, e1_d;
  logic              infl_q, infl_d, infl_pad_q, infl_pad_d;

  logic       issue, pad_line, last_col, cred_inc, cred_dec, pop;
  logic [1:0] occ;
  logic [7:0] in_data, stage0, stage1;

`ifdef PIXEL_STREAMER_PAD_EN
  assign pad_line = (line_q == LINE_W'(IMG_HEIGHT));
`else
  assign pad_line = 1'b0;
`endif

  // Datapath: the in-flight read counts as a FIFO slot, so occupancy never exceeds 2.
  always_comb begin
    occ          = cnt_q + {1'b0, infl_q};
    issue        = (state_q == SEND) && (occ < 2'd2);
    last_col     = (col_q == LAST_COL);
    in_data      = infl_pad_q ? 8'h00 : mem_data;
    o_data_valid = (cnt_q != 2'd0) || infl_q;
    o_data       = (cnt_q != 2'd0) ? e0_q : (infl_q ? in_data : 8'h00);
    pop          = o_data_valid && i_data_ready;
    stage0       = (cnt_q == 2'd0) ? in_data : e0_q;
    stage1       = (cnt_q == 2'd2) ? e1_q : in_data;
    cnt_d        = occ - {1'b0, pop};
    e0_d         = pop ? stage1 : stage0;
    e1_d         = stage1;
    infl_d       = issue;
    infl_pad_d   = issue && pad_line;

    col_d    = col_q;
    line_d   = line_q;
    addr_d   = addr_q;
    credit_d = credit_q;
    cred_inc = intr && (state_q != IDLE) && (state_q != DONE);
    cred_dec = issue && (col_q == '0);
    if (state_q == LOAD) begin
      col_d    = '0;
      line_d   = '0;
      addr_d   = '0;
      credit_d = CRED_MAX;
    end else begin
      if (issue) begin
        addr_d = addr_q + ADDR_W'(1);
        col_d  = last_col ? '0 : col_q + COL_W'(1);
        if (last_col) line_d = line_q + LINE_W'(1);
      end
      if (cred_inc && !cred_dec && credit_q != CRED_MAX) credit_d = credit_q + CRED_W'(1);
      else if (cred_dec && !cred_inc)                    credit_d = credit_q - CRED_W'(1);
    end
  end

  // Next-state decisions look at credit_d so a credit arriving this cycle counts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (start) state_d = LOAD;
      LOAD:        state_d = SEND;
      SEND: if (issue && last_col) begin
        if (line_q == LAST_LINE)   state_d = FLUSH;
        else if (credit_d != '0)   state_d = SEND;
        else                       state_d = WAIT_CREDIT;
      end
      WAIT_CREDIT: if (credit_d != '0) state_d = SEND;
      FLUSH:       if (cnt_d == 2'd0) state_d = DONE;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == LOAD) || (state_q == SEND) ||
                (state_q == WAIT_CREDIT) || (state_q == FLUSH);
    done      = (state_q == DONE);
    mem_rd_en = issue && !pad_line;
    mem_addr  = addr_q;
  end

  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      col_q      <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= 2'd0;
      e0_q       <= 8'h00;
      e1_q       <= 8'h00;
      infl_q     <= 1'b0;
      infl_pad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      col_q      <= col_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      infl_q     <= infl_d;
      infl_pad_q <= infl_pad_d;
    end
  end
endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer: expected raster bytes are queued at frame start
// and a negedge monitor pops and compares every accepted byte.
module tb_pixel_streamer;
  localparam int W = 4, H = 6, PL = 4, AW = 5;
`ifdef PIXEL_STREAMER_PAD_EN
  localparam int NLINES = H + 1;
`else
  localparam int NLINES = H;
`endif
  localparam int TOTAL = NLINES * W;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, ready = 1'b0, intr = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'h00;
  logic          o_data_valid;
  logic [7:0]    o_data;
  logic          busy, done;

  pixel_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .PRIME_LINES(PL)) dut (
    .axi_clk(clk), .axi_rst(rst_n), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(ready),
    .intr(intr), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // Frame memory holds memory[a] = a, one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_data <= {3'b000, mem_addr};

  int n_pass = 0, n_chk = 0;
  logic [7:0] exp_q[$];
  int intr_q[$];
  int cyc = 0, xfer_cnt = 0, rd_cnt = 0, done_cnt = 0, first_cyc = -1, last_cyc = -1;
  bit auto_intr = 1'b0, rand_ready = 1'b0, ready_fix = 1'b1;
  int man_pend = 0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Input driver: ready and intr change 1 time unit after the active edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    intr  = 1'b0;
    if (man_pend > 0) begin intr = 1'b1; man_pend--; end
    if (auto_intr && intr_q.size() > 0 && intr_q[0] <= cyc) begin
      intr = 1'b1;
      void'(intr_q.pop_front());
    end
  end

  // Monitor: compares accepted bytes, stream hold rule, and done timing.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin prev_hold = 1'b0; continue; end
    if (prev_hold) begin
      check("hold_valid", int'(o_data_valid), 1);
      check("hold_data", int'(o_data), int'(prev_data));
    end
    if (mem_rd_en) rd_cnt++;
    if (o_data_valid && ready) begin
      if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
      else check("byte", int'(o_data), int'(exp_q.pop_front()));
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      xfer_cnt++;
      if (auto_intr && (xfer_cnt % W) == 0) intr_q.push_back(cyc + 2);
    end
    if (done) begin
      done_cnt++;
      check("done_after_last", cyc, last_cyc + 1);
      check("busy_low_at_done", int'(busy), 0);
    end
    prev_hold = o_data_valid && !ready;
    prev_data = o_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_frame();
    exp_q.delete();
    intr_q.delete();
    for (int i = 0; i < TOTAL; i++) exp_q.push_back(i < H * W ? 8'(i) : 8'h00);
    xfer_cnt = 0; rd_cnt = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_xfer(input int n, input int budget, input string name);
    int k = 0;
    while (xfer_cnt < n && k < budget) begin tick(1); k++; end
    check(name, xfer_cnt, n);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin tick(1); k++; end
    check("done_seen", done_cnt, 1);
  endtask

  task automatic end_frame();
    tick(4);
    check("done_once", done_cnt, 1);
    check("busy_after", int'(busy), 0);
    check("bytes_total", xfer_cnt, TOTAL);
    check("exp_drained", exp_q.size(), 0);
    check("mem_reads", rd_cnt, H * W);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, int'(mem_rd_en), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
    check({tag, "_valid"}, int'(o_data_valid), 0);
    check({tag, "_data"}, int'(o_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Ready always high, credits returned 2 cycles after each line: full rate.
    ready_fix = 1'b1; auto_intr = 1'b1;
    start_frame();
    check("lat_busy_c1", int'(busy), 1);
    check("lat_rd_c1", int'(mem_rd_en), 0);
    tick(1);
    check("lat_rd_c2", int'(mem_rd_en), 1);
    check("lat_addr_c2", int'(mem_addr), 0);
    tick(1);
    check("lat_valid_c3", int'(o_data_valid), 1);
    check("lat_data_c3", int'(o_data), 0);
    wait_done(300);
    check("throughput", last_cyc - first_cyc, TOTAL - 1);
    end_frame();

    // No credits returned: stalls after PRIME_LINES lines; mid-frame start ignored.
    auto_intr = 1'b0;
    start_frame();
    wait_xfer(6, 100, "reach6");
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_xfer(4 * W, 100, "reach_prime");
    tick(8);
    check("stall_count", xfer_cnt, 4 * W);
    check("stall_valid", int'(o_data_valid), 0);
    check("stall_busy", int'(busy), 1);
    // Back-to-back pulses: the second lands on a line start and must not be lost.
    man_pend = NLINES - 4;
    wait_done(200);
    end_frame();

    // Random backpressure.
    rand_ready = 1'b1; auto_intr = 1'b1;
    start_frame();
    wait_done(2000);
    rand_ready = 1'b0; ready_fix = 1'b1;
    end_frame();

    // Credit saturation: 6 pulses early, while the stream is blocked.
    auto_intr = 1'b0; ready_fix = 1'b0;
    start_frame();
    man_pend = 6;
    tick(12);
    ready_fix = 1'b1;
    wait_xfer(5 * W, 200, "reach_sat");
    tick(8);
    check("sat_count", xfer_cnt, 5 * W);
    check("sat_valid", int'(o_data_valid), 0);
    man_pend = NLINES - 5;
    wait_done(200);
    end_frame();

    // Reset mid-frame, then restart from byte 0.
    auto_intr = 1'b1;
    start_frame();
    wait_xfer(10, 100, "reach10");
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete(); intr_q.delete(); man_pend = 0;
    tick(3);
    rst_n = 1'b1;
    check("no_done_on_reset", done_cnt, 0);
    tick(2);
    start_frame();
    wait_done(300);
    end_frame();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
